// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave: word-organised SRAM with byte/halfword/word writes and programmable wait states.
// OKAY data phase takes WAIT_STATES+1 cycles and ERROR takes 2; Hreadyout low stalls the bus.
module ahb_sram_slave #(
   parameter int DATA_W      = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int OFFSET_W    = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic              Hclk,
   input  logic              Hresetn,
   input  logic              Hsel,
   input  logic [31:0]       Haddr,
   input  logic [1:0]        Htrans,
   input  logic              Hwrite,
   input  logic [2:0]        Hsize,
   input  logic [DATA_W-1:0] Hwdata,
   input  logic              Hready,
   output logic              Hreadyout,
   output logic              Hresp,
   output logic [DATA_W-1:0] Hrdata
);
   localparam int          IDX_W     = $clog2(MEM_DEPTH);
   localparam logic [31:0] BYTE_SPAN = 32'(MEM_DEPTH * 4);

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [OFFSET_W-1:0] offset_q;
   logic                wr_q;
   logic [2:0]          size_q;
   logic [DATA_W-1:0]   mem [MEM_DEPTH];

   logic [OFFSET_W-1:0] offset_a;
   logic                ready_int, accept, addr_err, wr_commit;
   logic [3:0]          byte_en;
   logic [IDX_W-1:0]    idx;
   logic                unused_bits;

   assign unused_bits = ^{Haddr[31:OFFSET_W], Htrans[0], offset_q[OFFSET_W-1:IDX_W+2]};

   assign offset_a  = Haddr[OFFSET_W-1:0];
   assign ready_int = (state_q != ST_WAIT) && (state_q != ST_ERR1);
   assign accept    = Hsel && Hready && Htrans[1] && ready_int;
   assign addr_err  = (32'(offset_a) >= BYTE_SPAN) || (Hsize > 3'b010) ||
                      ((Hsize == 3'b001) && offset_a[0]) ||
                      ((Hsize == 3'b010) && (offset_a[1:0] != 2'b00));

   assign idx       = offset_q[IDX_W+1:2];
   assign wr_commit = (state_q == ST_DATA) && wr_q;

   assign Hreadyout = ready_int;
   assign Hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
   assign Hrdata    = ((state_q == ST_DATA) && !wr_q) ? mem[idx] : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = ST_DATA;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            // IDLE, DATA and ERR2 all present Hreadyout=1, so each can take a new address phase
            state_d = ST_IDLE;
            if (accept) begin
               if (addr_err)                state_d = ST_ERR1;
               else if (WAIT_STATES == 0)   state_d = ST_DATA;
               else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_STATES);
               end
            end
         end
      endcase
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         offset_q <= '0;
         wr_q     <= 1'b0;
         size_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            offset_q <= offset_a;
            wr_q     <= Hwrite;
            size_q   <= Hsize;
         end
      end
   end

   always_comb begin
      byte_en = 4'b1111;
      case (size_q)
         3'b000:  byte_en = 4'b0001 << offset_q[1:0];
         3'b001:  byte_en = offset_q[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   // Storage is deliberately not reset; only committed DATA-phase writes touch it
   always_ff @(posedge Hclk) begin
      if (wr_commit) begin
         for (int b = 0; b < 4; b++)
            if (byte_en[b]) mem[idx][8*b +: 8] <= Hwdata[8*b +: 8];
      end
   end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: directed AHB transfers on two instances (1 and 0 wait states), scoreboard-checked.
module tb_ahb_sram_slave;
   logic        Hclk = 1'b0;
   logic        Hresetn;
   logic [31:0] Haddr, Hwdata;
   logic [1:0]  Htrans;
   logic        Hwrite;
   logic [2:0]  Hsize;
   logic        hsel0, hsel1;
   logic        rdy0, rdy1, resp0, resp1;
   logic [31:0] rdata0, rdata1;

   always #5 Hclk = ~Hclk;

   ahb_sram_slave #(.WAIT_STATES(1)) dut0 (
      .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(hsel0), .Haddr(Haddr), .Htrans(Htrans),
      .Hwrite(Hwrite), .Hsize(Hsize), .Hwdata(Hwdata), .Hready(rdy0),
      .Hreadyout(rdy0), .Hresp(resp0), .Hrdata(rdata0));

   ahb_sram_slave #(.WAIT_STATES(0)) dut1 (
      .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(hsel1), .Haddr(Haddr), .Htrans(Htrans),
      .Hwrite(Hwrite), .Hsize(Hsize), .Hwdata(Hwdata), .Hready(rdy1),
      .Hreadyout(rdy1), .Hresp(resp1), .Hrdata(rdata1));

   typedef struct {
      logic        resp;
      logic [31:0] rdata;
      int          waits;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   bit          in_data = 1'b0;
   int          low_cnt = 0;
   int          checks = 0, failures = 0;
   bit          sel = 1'b0;

   logic        m_sel, m_rdy, m_resp;
   logic [31:0] m_rdata;
   assign m_sel   = sel ? hsel1  : hsel0;
   assign m_rdy   = sel ? rdy1   : rdy0;
   assign m_resp  = sel ? resp1  : resp0;
   assign m_rdata = sel ? rdata1 : rdata0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: tracks each accepted transfer through its data phase and scores it on completion
   always @(negedge Hclk) begin
      if (!Hresetn) begin
         in_data = 1'b0;
         cmp("reset_out", {m_rdata[31:2], m_rdy, m_resp}, {30'd0, 1'b1, 1'b0});
      end else begin
         if (in_data) begin
            if (!m_rdy) begin
               low_cnt++;
               cmp({cur.name, "_stall_resp"}, 32'(m_resp), 32'(cur.resp));
            end else begin
               cmp({cur.name, "_resp"},  32'(m_resp), 32'(cur.resp));
               cmp({cur.name, "_rdata"}, m_rdata, cur.rdata);
               cmp({cur.name, "_waits"}, 32'(low_cnt), 32'(cur.waits));
               in_data = 1'b0;
            end
         end else begin
            cmp("idle_out", {m_rdata[31:2], m_rdy, m_resp}, {30'd0, 1'b1, 1'b0});
         end
         if (m_sel && m_rdy && Htrans[1]) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL accept_unexpected: got accept expected none at %0t", $time);
            end else begin
               cur     = exp_q.pop_front();
               in_data = 1'b1;
               low_cnt = 0;
            end
         end
      end
   end

   task automatic wait_accept(input string nm);
      int n;
      for (n = 0; n < 40; n++) begin
         @(negedge Hclk);
         if (m_rdy) break;
      end
      checks++;
      if (n == 40) begin
         failures++;
         $display("FAIL %s_accept_timeout: got no Hreadyout expected Hreadyout=1 within 40 cycles", nm);
      end
      @(posedge Hclk); #1;
   endtask

   task automatic xfer(input logic [1:0] trans, input logic wr, input logic [2:0] sz,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rsp, input logic [31:0] rd, input int waits, input string nm);
      exp_t e;
      hsel0  = !sel;
      hsel1  = sel;
      Htrans = trans;
      Hwrite = wr;
      Hsize  = sz;
      Haddr  = addr;
      e.resp = rsp; e.rdata = rd; e.waits = waits; e.name = nm;
      exp_q.push_back(e);
      wait_accept(nm);
      Hwdata = wdata;
   endtask

   task automatic go_idle(input int n);
      hsel0  = 1'b0;
      hsel1  = 1'b0;
      Htrans = 2'b00;
      repeat (n) begin @(posedge Hclk); #1; end
   endtask

   localparam logic [1:0] NSEQ = 2'b10, SEQ = 2'b11;
   localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      Hresetn = 1'b0;
      hsel0 = 1'b0; hsel1 = 1'b0; Haddr = '0; Hwdata = '0;
      Htrans = 2'b00; Hwrite = 1'b0; Hsize = 3'b000;
      repeat (6) begin
         @(posedge Hclk); #1;
         hsel0  = 1'($urandom);
         hsel1  = 1'($urandom);
         Haddr  = $urandom;
         Htrans = 2'($urandom);
         Hwrite = 1'($urandom);
         Hsize  = 3'($urandom);
         Hwdata = $urandom;
      end
      go_idle(1);
      Hresetn = 1'b1;
      go_idle(1);

      // One wait state: basic word write then read
      xfer(NSEQ, 1'b1, SZ_W, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0, 1, "wr_word");
      go_idle(1);
      xfer(NSEQ, 1'b0, SZ_W, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF, 1, "rd_word");
      go_idle(1);

      // Lane writes, pipelined; full-width write data exposes unmasked lanes
      xfer(NSEQ, 1'b1, SZ_B, 32'h011, 32'h55555555, 1'b0, 32'h0, 1, "wr_byte1");
      xfer(NSEQ, 1'b1, SZ_H, 32'h012, 32'hA5A5A5A5, 1'b0, 32'h0, 1, "wr_half_hi");
      xfer(NSEQ, 1'b0, SZ_W, 32'h010, 32'h0, 1'b0, 32'hA5A555EF, 1, "rd_lanes");
      go_idle(2);

      // Error responses, none of which may disturb word 0
      xfer(NSEQ, 1'b1, SZ_W, 32'h000, 32'hCAFEF00D, 1'b0, 32'h0, 1, "wr_w0");
      xfer(NSEQ, 1'b1, SZ_W, 32'h002, 32'hFFFFFFFF, 1'b1, 32'h0, 1, "err_wr_word_mis");
      xfer(NSEQ, 1'b1, SZ_H, 32'h001, 32'hFFFFFFFF, 1'b1, 32'h0, 1, "err_wr_half_mis");
      xfer(NSEQ, 1'b0, SZ_W, 32'h002, 32'h0,        1'b1, 32'h0, 1, "err_rd_word_mis");
      xfer(NSEQ, 1'b0, SZ_B, 32'h400, 32'h0,        1'b1, 32'h0, 1, "err_rd_range");
      xfer(NSEQ, 1'b0, 3'b011, 32'h000, 32'h0,      1'b1, 32'h0, 1, "err_rd_size");
      xfer(NSEQ, 1'b0, SZ_W, 32'h000, 32'h0, 1'b0, 32'hCAFEF00D, 1, "rd_w0_after_err");
      go_idle(2);

      // IDLE/BUSY with select asserted: no transfer, no write
      hsel0 = 1'b1; Hwrite = 1'b1; Hsize = SZ_W; Haddr = 32'h010; Hwdata = 32'h0;
      Htrans = 2'b01;
      repeat (2) begin @(posedge Hclk); #1; end
      Htrans = 2'b00;
      repeat (2) begin @(posedge Hclk); #1; end
      xfer(NSEQ, 1'b0, SZ_W, 32'h010, 32'h0, 1'b0, 32'hA5A555EF, 1, "rd_after_busy");
      go_idle(1);

      // Reset in the middle of a write's wait state
      xfer(NSEQ, 1'b1, SZ_W, 32'h030, 32'h0BADF00D, 1'b0, 32'h0, 1, "wr_30");
      go_idle(1);
      xfer(NSEQ, 1'b1, SZ_W, 32'h030, 32'h12345678, 1'b0, 32'h0, 1, "wr_30_aborted");
      Hresetn = 1'b0;
      go_idle(2);
      Hresetn = 1'b1;
      go_idle(1);
      xfer(NSEQ, 1'b0, SZ_W, 32'h030, 32'h0, 1'b0, 32'h0BADF00D, 1, "rd_30_after_rst");
      go_idle(2);

      // Zero wait states: write then read-after-write in the write's data cycle
      sel = 1'b1;
      go_idle(1);
      xfer(NSEQ, 1'b1, SZ_W, 32'h020, 32'h11223344, 1'b0, 32'h0, 0, "ws0_wr");
      xfer(SEQ,  1'b0, SZ_W, 32'h020, 32'h0, 1'b0, 32'h11223344, 0, "ws0_raw");
      xfer(NSEQ, 1'b0, SZ_B, 32'h400, 32'h0, 1'b1, 32'h0, 1, "ws0_err_range");
      go_idle(3);

      cmp("drain", 32'(exp_q.size()) + 32'(in_data), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
